g15_drum_line: RTL and testbench
================================

// Module: g15_drum_line
// PURPOSE
// - Parametrised model of one G-15 drum recirculating line (long line 108 words, short line 4 words).
// - Serial bit-time interface to the CPU/memory datapath, same as the fixed lines.
// - Adds a host word port for load/dump/debug that the fixed lines lack, with a drum-synchronous FSM.
// - Adds a revolution sync-error monitor. Instantiated once per line under mem_top.
// PARAMETERS
// - WORD_BITS  29   bits per word (bit 0 leaves the head first).
// - WORDS      108  words per line; legal range 1..108.
// - LINE_ID    0    line number; reported on host_line, no behavioural effect.
// PORTS
// - CLOCK       in   1          system clock; the only clock.
// - rst         in   1          reset; synchronous, active-low.
// - bit_en      in   1          one-cycle strobe, once per drum bit time.
// - word_sync   in   1          with bit_en: head is at bit 0 of word 0.
// - wr_gate     in   1          CPU write gate; din replaces the recirculated bit.
// - din         in   1          CPU serial write data.
// - dout        out  1          bit under the read head (registered).
// - word_pos    out  $clog2(WORDS)  word currently under the head.
// - host_req    in   1          one-cycle request; sampled only in IDLE.
// - host_we     in   1          1 = write word, 0 = read word.
// - host_addr   in   7          target word.
// - host_wdata  in   WORD_BITS  write data.
// - host_rdata  out  WORD_BITS  read data; valid with host_ack.
// - host_ack    out  1          one-cycle completion pulse.
// - host_err    out  1          qualifies host_ack: bad address or write collision.
// - host_busy   out  1          FSM not in IDLE.
// - host_line   out  5          LINE_ID constant.
// - sync_err    out  1          sticky; cleared only by reset.
// BEHAVIOUR
// - Reset (rst=0 at a CLOCK edge):
//   - bit_ptr, word_pos and host FSM go to 0 / IDLE.
//   - Outputs dout, host_rdata, host_ack, host_err, host_busy and sync_err go to 0.
//   - Storage contents are retained, as on a real drum.
//   - A transfer cut off by reset gives no ack.
// - Storage is WORDS*WORD_BITS bits. bit_ptr = word_pos*WORD_BITS + bit_idx.
// - On each bit_en cycle:
//   - dout <= mem[bit_ptr] (read-before-write).
//   - If a write applies: mem[bit_ptr] <= new bit.
//   - bit_ptr advances and wraps from WORDS*WORD_BITS-1 to 0.
//   - dout is valid from the cycle after bit_en. No change between strobes.
// - word_sync with bit_en:
//   - If bit_ptr != 0: sync_err <= 1, and bit_ptr is forced so this bit is treated as word 0 bit 0.
//   - word_sync without bit_en is ignored.
// - Write priority per bit: wr_gate beats a host write.
//   - If both write the same bit: CPU data is stored and the collision flag is set.
// - Host FSM:
//   - IDLE:
//     - On host_req, latch we/addr/wdata.
//     - If addr >= WORDS: go to DONE with err=1.
//     - Otherwise go to WAIT.
//   - WAIT:
//     - Move to XFER on the bit_en where the head is at bit 0 of addr.
//     - That same strobe is transfer bit 0.
//   - XFER: one bit per bit_en, WORD_BITS bits in total.
//     - Read: shift mem bits into host_rdata, bit 0 first into bit 0.
//     - Write: store host_wdata[bit_idx].
//     - After the last bit: go to DONE.
//   - DONE:
//     - host_ack=1 for exactly one cycle. host_err = (bad address | collision).
//     - Then return to IDLE.
// - Latency:
//   - Valid address: worst case WORDS*WORD_BITS + WORD_BITS strobes plus 2 cycles.
//   - Bad address: ack 2 cycles after host_req.
// - host_req while busy is ignored. No queueing.
// - A word_sync correction during WAIT or XFER aborts the transfer: ack with err=1.
// STRUCTURE
// - g15_pkg holds:
//   - G15_WORD_BITS=29, G15_LONG_WORDS=108, G15_SHORT_WORDS=4.
//   - typedef enum {H_IDLE, H_WAIT, H_XFER, H_DONE} g15_host_state_t.
// - One sub-module: g15_line_ram.
//   - 1-bit wide, WORDS*WORD_BITS deep, single-port, read-before-write.
//   - Inferable as block RAM.
// TESTING
// - Reset, then 3132 strobes with word_sync on bit 0 -> sync_err=0, word_pos wraps 107->0.
// - WORDS=4: host write 0x1ABCDEF0 to word 2, then host read word 2 -> rdata=0x1ABCDEF0, err=0.
// - wr_gate=1, din=1 during word 5 of a host write of 0 to word 5 -> ack with err=1, stored word all ones.
// - host_addr=108 with WORDS=108 -> ack 2 cycles later, err=1, storage unchanged.
// - word_sync at bit_ptr=100 -> sync_err=1 sticky, dout realigned; a pending transfer gets err=1.
// - rst=0 during XFER -> no ack, busy=0 next cycle, previously written words intact.

Source files
------------

// File: rtl/g15_pkg.sv
// g15_pkg: shared constants, host FSM states and width helper for the G-15 drum lines
package g15_pkg;
  localparam int G15_WORD_BITS   = 29;
  localparam int G15_LONG_WORDS  = 108;
  localparam int G15_SHORT_WORDS = 4;
  typedef enum logic [1:0] {H_IDLE, H_WAIT, H_XFER, H_DONE} g15_host_state_t;
  function automatic int g15_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/g15_line_ram.sv
// g15_line_ram: 1-bit wide single-port read-before-write store holding one drum line
module g15_line_ram #(
  parameter int DEPTH = 3132,
  parameter int AW    = 12
) (
  input  logic          CLOCK,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          d,
  output logic          q
);
  logic mem [DEPTH];
  // storage write; never cleared, contents survive reset like the real drum
  always_ff @(posedge CLOCK)
    if (en && we) mem[addr] <= d;
  // registered read head, holds its value between strobes
  always_ff @(posedge CLOCK)
    if (!rst) q <= 1'b0;
    else if (en) q <= mem[addr];
endmodule

// File: rtl/g15_drum_line.sv
// g15_drum_line: one recirculating drum line with serial CPU port, host word port and sync monitor
module g15_drum_line
  import g15_pkg::*;
#(
  parameter int WORD_BITS = G15_WORD_BITS,
  parameter int WORDS     = G15_LONG_WORDS,
  parameter int LINE_ID   = 0
) (
  input  logic                       CLOCK,
  input  logic                       rst,
  input  logic                       bit_en,
  input  logic                       word_sync,
  input  logic                       wr_gate,
  input  logic                       din,
  output logic                       dout,
  output logic [g15_w(WORDS)-1:0]    word_pos,
  input  logic                       host_req,
  input  logic                       host_we,
  input  logic [6:0]                 host_addr,
  input  logic [WORD_BITS-1:0]       host_wdata,
  output logic [WORD_BITS-1:0]       host_rdata,
  output logic                       host_ack,
  output logic                       host_err,
  output logic                       host_busy,
  output logic [4:0]                 host_line,
  output logic                       sync_err
);
  localparam int N   = WORDS * WORD_BITS;
  localparam int PW  = g15_w(N);
  localparam int IW  = g15_w(WORD_BITS);
  localparam int WPW = g15_w(WORDS);
  g15_host_state_t state, nxt;
  logic [PW-1:0]        bit_ptr, cur_ptr, nxt_ptr;
  logic [IW-1:0]        bit_idx, cur_idx, nxt_idx, rd_idx;
  logic [WPW-1:0]       cur_word, nxt_word;
  logic                 corr, live, accept, bad, at_start, last, xfer, hw, ram_we, ram_d;
  logic                 h_we, col, err_f, rd_v;
  logic [6:0]           h_addr;
  logic [WORD_BITS-1:0] h_wdata;
  assign corr      = bit_en & word_sync & (bit_ptr != '0);
  assign cur_ptr   = corr ? '0 : bit_ptr;
  assign cur_idx   = corr ? '0 : bit_idx;
  assign cur_word  = corr ? '0 : word_pos;
  assign last      = cur_idx == IW'(WORD_BITS - 1);
  assign nxt_ptr   = cur_ptr == PW'(N - 1) ? '0 : cur_ptr + 1'b1;
  assign nxt_idx   = last ? '0 : cur_idx + 1'b1;
  assign nxt_word  = !last ? cur_word : cur_word == WPW'(WORDS - 1) ? '0 : cur_word + 1'b1;
  assign live      = (state == H_WAIT) | (state == H_XFER);
  assign accept    = (state == H_IDLE) & host_req;
  assign bad       = int'(host_addr) >= WORDS;
  assign at_start  = (cur_idx == '0) & (7'(cur_word) == h_addr);
  assign hw        = xfer & h_we;
  assign ram_we    = wr_gate | hw;
  assign ram_d     = wr_gate ? din : h_wdata[cur_idx];
  assign host_busy = state != H_IDLE;
  assign host_line = 5'(LINE_ID);
  g15_line_ram #(.DEPTH(N), .AW(PW)) u_ram (
    .CLOCK (CLOCK),
    .rst   (rst),
    .en    (bit_en & rst),
    .we    (ram_we),
    .addr  (cur_ptr),
    .d     (ram_d),
    .q     (dout)
  );
  // host FSM state register
  always_ff @(posedge CLOCK)
    if (!rst) state <= H_IDLE;
    else state <= nxt;
  // host FSM next state; a realignment while a transfer is pending aborts it
  always_comb begin
    nxt  = state;
    xfer = 1'b0;
    if (accept) nxt = bad ? H_DONE : H_WAIT;
    else if (live & corr) nxt = H_DONE;
    else if (bit_en & ((state == H_XFER) | ((state == H_WAIT) & at_start))) begin
      xfer = 1'b1;
      nxt  = last ? H_DONE : H_XFER;
    end
    else if (state == H_DONE) nxt = H_IDLE;
  end
  // request latches and error flags, meaningful only between accept and ack
  always_ff @(posedge CLOCK) begin
    if (accept) begin
      h_we    <= host_we;
      h_addr  <= host_addr;
      h_wdata <= host_wdata;
    end
    col   <= accept ? 1'b0 : col | (hw & wr_gate);
    err_f <= accept ? bad : err_f | (live & corr);
  end
  // head position, sync monitor, read capture one cycle behind the RAM and ack pulse
  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      bit_ptr    <= '0;
      bit_idx    <= '0;
      word_pos   <= '0;
      sync_err   <= 1'b0;
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
      host_rdata <= '0;
      rd_v       <= 1'b0;
    end else begin
      host_ack <= state == H_DONE;
      host_err <= (state == H_DONE) & (err_f | col);
      rd_v     <= xfer & ~h_we;
      rd_idx   <= cur_idx;
      sync_err <= sync_err | corr;
      if (accept) host_rdata <= '0;
      else if (rd_v) host_rdata[rd_idx] <= dout;
      if (bit_en) begin
        bit_ptr  <= nxt_ptr;
        bit_idx  <= nxt_idx;
        word_pos <= nxt_word;
      end
    end
  end
endmodule

// File: tb/tb_g15_drum_line.sv
// tb_g15_drum_line: scoreboard bench for a long (108-word) and a short (4-word) drum line
module tb_g15_drum_line;
  typedef struct packed {logic err; logic chk; logic [28:0] data;} exp_t;
  localparam int NL = 3132;
  localparam int NS = 116;
  logic CLOCK = 1'b0, rst = 1'b0, bit_en = 1'b0;
  logic ws_l = 1'b0, wg_l = 1'b0, din_l = 1'b0, req_l = 1'b0, we_l = 1'b0;
  logic ws_s = 1'b0, wg_s = 1'b0, din_s = 1'b0, req_s = 1'b0, we_s = 1'b0;
  logic [6:0] addr_l = '0, addr_s = '0;
  logic [28:0] wd_l = '0, wd_s = '0;
  logic dout_l, ack_l, err_l, busy_l, serr_l, dout_s, ack_s, err_s, busy_s, serr_s;
  logic [6:0] wp_l;
  logic [1:0] wp_s;
  logic [28:0] rd_l, rd_s;
  logic [4:0] line_l, line_s;
  int nchk = 0, nerr = 0, m_l = 0, m_s = 0, force_at = -1;
  bit run = 0, sync_on = 0, cpu_w5 = 0;
  exp_t q_l[$], q_s[$];

  g15_drum_line #(.WORD_BITS(29), .WORDS(108), .LINE_ID(3)) dut_l (
    .CLOCK(CLOCK), .rst(rst), .bit_en(bit_en), .word_sync(ws_l), .wr_gate(wg_l), .din(din_l),
    .dout(dout_l), .word_pos(wp_l), .host_req(req_l), .host_we(we_l), .host_addr(addr_l),
    .host_wdata(wd_l), .host_rdata(rd_l), .host_ack(ack_l), .host_err(err_l), .host_busy(busy_l),
    .host_line(line_l), .sync_err(serr_l));
  g15_drum_line #(.WORD_BITS(29), .WORDS(4), .LINE_ID(1)) dut_s (
    .CLOCK(CLOCK), .rst(rst), .bit_en(bit_en), .word_sync(ws_s), .wr_gate(wg_s), .din(din_s),
    .dout(dout_s), .word_pos(wp_s), .host_req(req_s), .host_we(we_s), .host_addr(addr_s),
    .host_wdata(wd_s), .host_rdata(rd_s), .host_ack(ack_s), .host_err(err_s), .host_busy(busy_s),
    .host_line(line_s), .sync_err(serr_s));

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // strobe generator with a model of the head position of each line
  initial forever begin
    @(posedge CLOCK);
    if (!rst) begin
      m_l = 0;
      m_s = 0;
    end else if (bit_en) begin
      m_l = ws_l ? 1 : (m_l + 1) % NL;
      m_s = ws_s ? 1 : (m_s + 1) % NS;
    end
    #1;
    if (run && !bit_en) begin
      bit_en = 1'b1;
      ws_l = (sync_on && m_l == 0) || m_l == force_at;
      if (m_l == force_at) force_at = -1;
      ws_s = sync_on && m_s == 0;
      wg_l = cpu_w5 && m_l >= 145 && m_l < 174;
      din_l = wg_l;
    end else begin
      bit_en = 1'b0;
      ws_l = 1'b0;
      ws_s = 1'b0;
      wg_l = 1'b0;
      din_l = 1'b0;
    end
  end

  // scoreboard monitor: every ack pops one expected completion
  always @(negedge CLOCK) begin
    exp_t e;
    if (ack_l) begin
      if (q_l.size() == 0) chk("ack_l_unexpected", 32'(ack_l), 32'd0);
      else begin
        e = q_l.pop_front();
        chk("err_l", 32'(err_l), 32'(e.err));
        if (e.chk) chk("rdata_l", 32'(rd_l), 32'(e.data));
      end
    end
    if (ack_s) begin
      if (q_s.size() == 0) chk("ack_s_unexpected", 32'(ack_s), 32'd0);
      else begin
        e = q_s.pop_front();
        chk("err_s", 32'(err_s), 32'(e.err));
        if (e.chk) chk("rdata_s", 32'(rd_s), 32'(e.data));
      end
    end
  end

  task automatic wait_m(input bit s, input int tgt);
    for (int i = 0; i < 20000 && (s ? m_s : m_l) != tgt; i++) @(negedge CLOCK);
    chk(s ? "head_s" : "head_l", s ? m_s : m_l, tgt);
  endtask

  task automatic drain(input bit s);
    for (int i = 0; i < 20000 && (s ? (busy_s || q_s.size() != 0) : (busy_l || q_l.size() != 0)); i++)
      @(negedge CLOCK);
    chk(s ? "drain_s" : "drain_l", s ? q_s.size() + 32'(busy_s) : q_l.size() + 32'(busy_l), 0);
  endtask

  task automatic host(input bit s, input bit we, input logic [6:0] a, input logic [28:0] wd,
                      input bit push, input bit err, input bit ck, input logic [28:0] rd);
    drain(s);
    if (push && s) q_s.push_back(exp_t'({err, ck, rd}));
    if (push && !s) q_l.push_back(exp_t'({err, ck, rd}));
    @(posedge CLOCK); #1;
    if (s) begin req_s = 1'b1; we_s = we; addr_s = a; wd_s = wd; end
    else begin req_l = 1'b1; we_l = we; addr_l = a; wd_l = wd; end
    @(posedge CLOCK); #1;
    req_s = 1'b0;
    req_l = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_dout", 32'(dout_l), 0);
    chk("rst_word_pos", 32'(wp_l), 0);
    chk("rst_busy", 32'(busy_l), 0);
    chk("rst_ack", 32'(ack_l), 0);
    chk("rst_err", 32'(err_l), 0);
    chk("rst_rdata", 32'(rd_l), 0);
    chk("rst_sync_err", 32'(serr_l), 0);
    chk("line_l", 32'(line_l), 3);
    chk("line_s", 32'(line_s), 1);
    @(posedge CLOCK); #1;
    rst = 1'b1;
    sync_on = 1;
    run = 1;
    wait_m(0, NL - 1);
    chk("word_pos_107", 32'(wp_l), 107);
    wait_m(0, 0);
    chk("word_pos_wrap", 32'(wp_l), 0);
    wait_m(0, 1);
    wait_m(0, 0);
    chk("sync_ok_l", 32'(serr_l), 0);
    chk("sync_ok_s", 32'(serr_s), 0);
    host(1, 1, 2, 29'h1ABCDEF0, 1, 0, 0, 0);
    host(1, 0, 2, 0, 1, 0, 1, 29'h1ABCDEF0);
    host(1, 1, 4, 29'h1FFFFFFF, 1, 1, 0, 0);
    host(1, 0, 2, 0, 1, 0, 1, 29'h1ABCDEF0);
    host(0, 1, 0, 29'h15555555, 1, 0, 0, 0);
    host(0, 1, 3, 0, 1, 0, 0, 0);
    cpu_w5 = 1;
    host(0, 1, 5, 0, 1, 1, 0, 0);
    drain(0);
    cpu_w5 = 0;
    host(0, 0, 5, 0, 1, 0, 1, 29'h1FFFFFFF);
    drain(0);
    q_l.push_back(exp_t'({1'b1, 1'b0, 29'h0}));
    @(posedge CLOCK); #1;
    req_l = 1'b1; we_l = 1'b1; addr_l = 7'd108; wd_l = 29'h0;
    @(negedge CLOCK);
    chk("bad_ack_c0", 32'(ack_l), 0);
    @(posedge CLOCK); #1;
    req_l = 1'b0;
    @(negedge CLOCK);
    chk("bad_ack_c1", 32'(ack_l), 0);
    chk("bad_busy_c1", 32'(busy_l), 1);
    @(negedge CLOCK);
    chk("bad_ack_c2", 32'(ack_l), 1);
    host(0, 0, 0, 0, 1, 0, 1, 29'h15555555);
    drain(0);
    wait_m(0, 10);
    host(0, 0, 50, 0, 1, 1, 0, 0);
    force_at = 100;
    for (int i = 0; i < 20000 && force_at != -1; i++) @(negedge CLOCK);
    chk("force_issued", force_at, -1);
    @(negedge CLOCK);
    chk("realign_dout0", 32'(dout_l), 1);
    chk("realign_sync_err", 32'(serr_l), 1);
    chk("realign_word_pos", 32'(wp_l), 0);
    repeat (2) @(negedge CLOCK);
    chk("realign_dout1", 32'(dout_l), 0);
    repeat (2) @(negedge CLOCK);
    chk("realign_dout2", 32'(dout_l), 1);
    drain(0);
    chk("sync_err_sticky", 32'(serr_l), 1);
    drain(1);
    wait_m(1, 100);
    host(1, 1, 1, 29'h0AAAAAAA, 0, 0, 0, 0);
    wait_m(1, 40);
    chk("xfer_busy", 32'(busy_s), 1);
    @(posedge CLOCK); #1;
    rst = 1'b0;
    @(posedge CLOCK); #1;
    rst = 1'b1;
    @(negedge CLOCK);
    chk("cut_busy", 32'(busy_s), 0);
    chk("cut_ack", 32'(ack_s), 0);
    chk("cut_dout", 32'(dout_s), 0);
    chk("cut_sync_err", 32'(serr_l), 0);
    repeat (20) @(negedge CLOCK);
    host(1, 0, 2, 0, 1, 0, 1, 29'h1ABCDEF0);
    host(0, 0, 0, 0, 1, 0, 1, 29'h15555555);
    drain(0);
    drain(1);
    repeat (5) @(negedge CLOCK);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
